// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulator-control port arbiter.
// Word indices are addr[9:2] of the device register map.
package sim_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_RSP = 2'd1,
      ST_HALTED   = 2'd2
   } arb_state_e;

   localparam logic [7:0]  CHAR_OUT_WORD = 8'h0;
   localparam logic [7:0]  SIM_CTRL_WORD = 8'h2;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Produces a one-hot grant, its index and a valid flag.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int c;

   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         c = (int'(ptr_i) + i) % N;
         if (req_i[c]) begin
            gnt_o    = '0;
            gnt_o[c] = 1'b1;
            idx_o    = IW'(c);
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sim_ctrl_arbiter.sv
// Shares the simulator-control device port between NumReq requesters: round-robin grant,
// one outstanding transaction, response routing, response timeout and a halt lock.
module sim_ctrl_arbiter
   import sim_ctrl_pkg::*;
#(
   parameter int         NumReq       = 2,
   parameter int         RspTimeout   = 16,
   parameter logic [7:0] HaltWordAddr = SIM_CTRL_WORD
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumReq-1:0]    req_i,
   input  logic [NumReq-1:0]    we_i,
   input  logic [NumReq*4-1:0]  be_i,
   input  logic [NumReq*32-1:0] addr_i,
   input  logic [NumReq*32-1:0] wdata_i,
   output logic [NumReq-1:0]    gnt_o,
   output logic [NumReq-1:0]    rvalid_o,
   output logic [NumReq-1:0]    err_o,
   output logic [31:0]          rdata_o,
   output logic                 dev_req_o,
   output logic                 dev_we_o,
   output logic [3:0]           dev_be_o,
   output logic [31:0]          dev_addr_o,
   output logic [31:0]          dev_wdata_o,
   input  logic                 dev_rvalid_i,
   input  logic [31:0]          dev_rdata_i,
   output logic                 halted_o
);

   localparam int IW = $clog2(NumReq);
   localparam int TW = $clog2(RspTimeout);
   localparam logic [TW-1:0] TMO_LAST = TW'(RspTimeout - 1);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          halt_pend_q, halt_pend_d;
   logic          loc_rsp_q, loc_rsp_d;

   logic [NumReq-1:0] arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic              arb_valid;
   logic              sel_we;
   logic [3:0]        sel_be;
   logic [31:0]       sel_addr, sel_wdata;
   logic              halt_hit;
   logic              can_grant, grant, rsp_norm, rsp_tmo, rsp_loc;

   rr_arbiter #(.N(NumReq), .IW(IW)) u_rr (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      sel_we    = we_i[arb_idx];
      sel_be    = be_i[arb_idx*4 +: 4];
      sel_addr  = addr_i[arb_idx*32 +: 32];
      sel_wdata = wdata_i[arb_idx*32 +: 32];
      halt_hit  = sel_we && (sel_addr[9:2] == HaltWordAddr) && sel_be[0] && sel_wdata[0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (grant) state_d = ST_WAIT_RSP;
         ST_WAIT_RSP: if (rsp_norm || rsp_tmo)
                         state_d = halt_pend_q ? ST_HALTED : (grant ? ST_WAIT_RSP : ST_IDLE);
         ST_HALTED:   state_d = ST_HALTED;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Everything is gated by rst_i so nothing leaks out while reset is applied mid-transaction.
   always_comb begin
      can_grant = 1'b0;
      rsp_norm  = 1'b0;
      rsp_tmo   = 1'b0;
      rsp_loc   = 1'b0;
      if (!rst_i) begin
         case (state_q)
            ST_IDLE: can_grant = 1'b1;
            ST_WAIT_RSP: begin
               rsp_norm  = dev_rvalid_i;
               rsp_tmo   = !dev_rvalid_i && (timer_q == TMO_LAST);
               can_grant = dev_rvalid_i && !halt_pend_q;
            end
            ST_HALTED: begin
               can_grant = 1'b1;
               rsp_loc   = loc_rsp_q;
            end
            default: ;
         endcase
      end
      grant       = can_grant && arb_valid;
      gnt_o       = grant ? arb_gnt : '0;
      dev_req_o   = grant && (state_q != ST_HALTED);
      dev_we_o    = dev_req_o && sel_we;
      dev_be_o    = dev_req_o ? sel_be : 4'h0;
      dev_addr_o  = dev_req_o ? sel_addr : 32'h0;
      dev_wdata_o = dev_req_o ? sel_wdata : 32'h0;
      rvalid_o    = '0;
      err_o       = '0;
      if (rsp_norm || rsp_tmo || rsp_loc) rvalid_o[owner_q] = 1'b1;
      if (rsp_tmo) err_o[owner_q] = 1'b1;
      rdata_o  = rsp_norm ? dev_rdata_i : (rsp_tmo ? TIMEOUT_RDATA : 32'h0);
      halted_o = !rst_i && (state_q == ST_HALTED);
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      timer_d     = timer_q;
      halt_pend_d = halt_pend_q;
      loc_rsp_d   = grant && (state_q == ST_HALTED);
      if (state_q == ST_WAIT_RSP) timer_d = timer_q + TW'(1);
      if (rsp_norm || rsp_tmo) halt_pend_d = 1'b0;
      if (grant) begin
         rr_ptr_d    = (arb_idx == IW'(NumReq - 1)) ? '0 : arb_idx + IW'(1);
         owner_d     = arb_idx;
         timer_d     = '0;
         halt_pend_d = dev_req_o && halt_hit;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         timer_q     <= '0;
         halt_pend_q <= 1'b0;
         loc_rsp_q   <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         timer_q     <= timer_d;
         halt_pend_q <= halt_pend_d;
         loc_rsp_q   <= loc_rsp_d;
      end
   end

endmodule

// File: tb/tb_sim_ctrl_arbiter.sv
// Directed, table-driven bench for sim_ctrl_arbiter (NumReq=2, RspTimeout=16).
// Each vector is one clock cycle: inputs applied after the edge, outputs checked mid-cycle.
module tb_sim_ctrl_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_i, we_i;
   logic [7:0]  be_i;
   logic [63:0] addr_i, wdata_i;
   logic [1:0]  gnt_o, rvalid_o, err_o;
   logic [31:0] rdata_o;
   logic        dev_req_o, dev_we_o;
   logic [3:0]  dev_be_o;
   logic [31:0] dev_addr_o, dev_wdata_o;
   logic        dev_rvalid_i;
   logic [31:0] dev_rdata_i;
   logic        halted_o;

   int checks = 0;
   int errors = 0;

   sim_ctrl_arbiter #(.NumReq(2), .RspTimeout(16), .HaltWordAddr(8'h2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .err_o(err_o), .rdata_o(rdata_o), .dev_req_o(dev_req_o), .dev_we_o(dev_we_o),
      .dev_be_o(dev_be_o), .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o),
      .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .halted_o(halted_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic        rst;
      logic [1:0]  req;
      logic        dv;
      logic [31:0] drd;
      logic [1:0]  e_gnt, e_rv, e_err;
      logic [31:0] e_rdata;
      logic        e_dreq, e_dwe;
      logic [3:0]  e_dbe;
      logic [31:0] e_daddr, e_dwdata;
      logic        e_halt;
   } vec_t;

   function automatic vec_t mk(string n, logic rst, logic [1:0] req, logic dv, logic [31:0] drd,
                               logic [1:0] gnt, logic [1:0] rv, logic [1:0] err, logic [31:0] rdata,
                               logic dreq, logic dwe, logic [3:0] dbe, logic [31:0] daddr,
                               logic [31:0] dwdata, logic halt);
      vec_t v;
      v.name = n;   v.rst = rst;   v.req = req;     v.dv = dv;         v.drd = drd;
      v.e_gnt = gnt; v.e_rv = rv;  v.e_err = err;   v.e_rdata = rdata;
      v.e_dreq = dreq; v.e_dwe = dwe; v.e_dbe = dbe; v.e_daddr = daddr;
      v.e_dwdata = dwdata; v.e_halt = halt;
      return v;
   endfunction

   task automatic chk(string n, string f, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s got %h want %h", n, f, got, want);
      end
   endtask

   task automatic set_fields(logic [1:0] we, logic [3:0] be0, logic [3:0] be1,
                             logic [31:0] a0, logic [31:0] a1, logic [31:0] w0, logic [31:0] w1);
      we_i    = we;
      be_i    = {be1, be0};
      addr_i  = {a1, a0};
      wdata_i = {w1, w0};
   endtask

   task automatic apply(vec_t v);
      rst_i        = v.rst;
      req_i        = v.req;
      dev_rvalid_i = v.dv;
      dev_rdata_i  = v.drd;
      #4;
      chk(v.name, "gnt",    32'(gnt_o),    32'(v.e_gnt));
      chk(v.name, "rvalid", 32'(rvalid_o), 32'(v.e_rv));
      chk(v.name, "err",    32'(err_o),    32'(v.e_err));
      chk(v.name, "rdata",  rdata_o,       v.e_rdata);
      chk(v.name, "dreq",   32'(dev_req_o), 32'(v.e_dreq));
      chk(v.name, "dwe",    32'(dev_we_o), 32'(v.e_dwe));
      chk(v.name, "dbe",    32'(dev_be_o), 32'(v.e_dbe));
      chk(v.name, "daddr",  dev_addr_o,    v.e_daddr);
      chk(v.name, "dwdata", dev_wdata_o,   v.e_dwdata);
      chk(v.name, "halted", 32'(halted_o), 32'(v.e_halt));
      $display("vec %-14s req=%b dv=%b gnt=%b rvalid=%b err=%b rdata=%h dreq=%b halted=%b",
               v.name, v.req, v.dv, gnt_o, rvalid_o, err_o, rdata_o, dev_req_o, halted_o);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_wait(string n, int cycles);
      for (int k = 0; k < cycles; k++)
         apply(mk(n, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0, 0, 0, 0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl_rr[$];
      vec_t tbl_wr[$];
      vec_t tbl_rst[$];
      vec_t tbl_halt[$];

      // Round-robin with back-to-back responses, stray response in IDLE dropped.
      tbl_rr.push_back(mk("reset",    1, 2'b11, 0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,  0));
      tbl_rr.push_back(mk("rr0",      0, 2'b11, 0, 32'h0,  2'b01, 2'b00, 2'b00, 32'h0,  1, 0, 4'hF, 32'h100, 32'hA0, 0));
      tbl_rr.push_back(mk("rr1",      0, 2'b11, 1, 32'h11, 2'b10, 2'b01, 2'b00, 32'h11, 1, 0, 4'hF, 32'h200, 32'hB1, 0));
      tbl_rr.push_back(mk("rr2",      0, 2'b11, 1, 32'h22, 2'b01, 2'b10, 2'b00, 32'h22, 1, 0, 4'hF, 32'h100, 32'hA0, 0));
      tbl_rr.push_back(mk("rr3",      0, 2'b11, 1, 32'h33, 2'b10, 2'b01, 2'b00, 32'h33, 1, 0, 4'hF, 32'h200, 32'hB1, 0));
      tbl_rr.push_back(mk("rr_last",  0, 2'b00, 1, 32'h44, 2'b00, 2'b10, 2'b00, 32'h44, 0, 0, 4'h0, 32'h0,   32'h0,  0));
      tbl_rr.push_back(mk("late_drop",0, 2'b00, 1, 32'h55, 2'b00, 2'b00, 2'b00, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,  0));

      // Character write from requester 1 does not halt.
      tbl_wr.push_back(mk("wr_char",  0, 2'b10, 0, 32'h0,  2'b10, 2'b00, 2'b00, 32'h0,  1, 1, 4'h1, 32'h0,   32'h41, 0));
      tbl_wr.push_back(mk("wr_rsp",   0, 2'b00, 1, 32'h0,  2'b00, 2'b10, 2'b00, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,  0));
      tbl_wr.push_back(mk("wr_idle",  0, 2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,  0));

      // Reset mid-transaction with rr pointer at 1.
      tbl_rst.push_back(mk("rst_gnt",   0, 2'b01, 0, 32'h0,  2'b01, 2'b00, 2'b00, 32'h0,  1, 0, 4'hF, 32'h100, 32'hA0, 0));
      tbl_rst.push_back(mk("rst_mid",   1, 2'b11, 1, 32'h5,  2'b00, 2'b00, 2'b00, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,  0));
      tbl_rst.push_back(mk("rst_after", 0, 2'b11, 1, 32'h55, 2'b01, 2'b00, 2'b00, 32'h0,  1, 0, 4'hF, 32'h100, 32'hA0, 0));
      tbl_rst.push_back(mk("rst_rsp",   0, 2'b00, 1, 32'h77, 2'b00, 2'b01, 2'b00, 32'h77, 0, 0, 4'h0, 32'h0,   32'h0,  0));

      // Halt write from requester 0, then locally answered requests.
      tbl_halt.push_back(mk("halt_gnt",   0, 2'b01, 0, 32'h0,  2'b01, 2'b00, 2'b00, 32'h0, 1, 1, 4'hF, 32'h8, 32'h1, 0));
      tbl_halt.push_back(mk("halt_rsp",   0, 2'b00, 1, 32'h0,  2'b00, 2'b01, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0));
      tbl_halt.push_back(mk("hlt_gnt1",   0, 2'b10, 0, 32'h0,  2'b10, 2'b00, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1));
      tbl_halt.push_back(mk("hlt_rsp1",   0, 2'b11, 0, 32'h0,  2'b01, 2'b10, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1));
      tbl_halt.push_back(mk("hlt_rsp0",   0, 2'b00, 1, 32'h99, 2'b00, 2'b01, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1));
      tbl_halt.push_back(mk("hlt_idle",   0, 2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1));
      tbl_halt.push_back(mk("final_rst",  1, 2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0));
      tbl_halt.push_back(mk("final_idle", 0, 2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0));

      rst_i = 1'b1; req_i = 2'b00; dev_rvalid_i = 1'b0; dev_rdata_i = 32'h0;
      set_fields(2'b00, 4'hF, 4'hF, 32'h100, 32'h200, 32'hA0, 32'hB1);
      repeat (2) @(posedge clk_i);
      #1;

      foreach (tbl_rr[i]) apply(tbl_rr[i]);

      set_fields(2'b10, 4'hF, 4'h1, 32'h100, 32'h0, 32'hA0, 32'h41);
      foreach (tbl_wr[i]) apply(tbl_wr[i]);

      // Timeout: no response for RspTimeout cycles after the grant.
      set_fields(2'b00, 4'hF, 4'hF, 32'h100, 32'h200, 32'hA0, 32'hB1);
      apply(mk("tmo_gnt",  0, 2'b01, 0, 32'h0,  2'b01, 2'b00, 2'b00, 32'h0, 1, 0, 4'hF, 32'h100, 32'hA0, 0));
      idle_wait("tmo_wait", 15);
      apply(mk("tmo_hit",  0, 2'b10, 0, 32'h0,  2'b00, 2'b01, 2'b01, 32'hDEAD_BEEF, 0, 0, 4'h0, 32'h0, 32'h0, 0));
      apply(mk("tmo_next", 0, 2'b10, 0, 32'h0,  2'b10, 2'b00, 2'b00, 32'h0, 1, 0, 4'hF, 32'h200, 32'hB1, 0));
      apply(mk("tmo_nrsp", 0, 2'b00, 1, 32'h12, 2'b00, 2'b10, 2'b00, 32'h12, 0, 0, 4'h0, 32'h0, 32'h0, 0));

      // Response arriving exactly on the timeout cycle wins.
      apply(mk("sim_gnt",  0, 2'b01, 0, 32'h0,  2'b01, 2'b00, 2'b00, 32'h0, 1, 0, 4'hF, 32'h100, 32'hA0, 0));
      idle_wait("sim_wait", 15);
      apply(mk("sim_hit",  0, 2'b00, 1, 32'h66, 2'b00, 2'b01, 2'b00, 32'h66, 0, 0, 4'h0, 32'h0, 32'h0, 0));

      foreach (tbl_rst[i]) apply(tbl_rst[i]);

      set_fields(2'b01, 4'hF, 4'hF, 32'h8, 32'h200, 32'h1, 32'hB1);
      foreach (tbl_halt[i]) apply(tbl_halt[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
